// File: rtl/serial_logic_processor.sv
// Two WIDTH-bit registers combined bit-serially (LSB first) by a selectable bitwise function.
// Define SERIAL_LOGIC_PROCESSOR_PARALLEL_EXEC_EN to compute the whole result in a single SHIFT cycle.
module serial_logic_processor #(
    parameter int WIDTH = 8,
    parameter int OPS_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
    output logic             Done,
    output logic [OPS_W-1:0] OpCount,
    output logic [1:0]       fsm_state
);

    // Handshake: Execute is a level request, sampled only in IDLE. Busy is high while SHIFT runs.
    // Done pulses for one cycle in the first HOLD cycle. HOLD is left only after Execute drops.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       f_q;
    logic [1:0]       r_q;
    logic [OPS_W-1:0] op_count;
    logic             fresh;
    logic             shift_last;

    function automatic logic logic_f(input logic [2:0] fs, input logic x, input logic y);
        case (fs)
            3'b000:  logic_f = x & y;
            3'b001:  logic_f = x | y;
            3'b010:  logic_f = x ^ y;
            3'b011:  logic_f = 1'b1;
            3'b100:  logic_f = ~(x & y);
            3'b101:  logic_f = ~(x | y);
            3'b110:  logic_f = ~(x ^ y);
            default: logic_f = 1'b0;
        endcase
    endfunction

`ifdef SERIAL_LOGIC_PROCESSOR_PARALLEL_EXEC_EN
    logic [WIDTH-1:0] f_vec, a_new, b_new;

    assign shift_last = 1'b1;

    always_comb begin
        f_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f_vec[i] = logic_f(f_q, a[i], b[i]);
        end
        a_new = a;
        b_new = b;
        case (r_q)
            2'b01:   b_new = f_vec;
            2'b10:   a_new = f_vec;
            2'b11:   begin a_new = b; b_new = a; end
            default: ;
        endcase
    end
`else
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic             f_bit, a_in, b_in;
    logic [WIDTH-1:0] a_new, b_new;

    assign shift_last = (cnt == CNT_W'(WIDTH - 1));

    // Each edge rotates both registers right; the routed bit enters at the MSB.
    always_comb begin
        f_bit = logic_f(f_q, a[0], b[0]);
        a_in  = a[0];
        b_in  = b[0];
        case (r_q)
            2'b01:   b_in = f_bit;
            2'b10:   a_in = f_bit;
            2'b11:   begin a_in = b[0]; b_in = a[0]; end
            default: ;
        endcase
        a_new = {a_in, a[WIDTH-1:1]};
        b_new = {b_in, b[WIDTH-1:1]};
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (state == SHIFT) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Execute && !LoadA && !LoadB) state_next = SHIFT;
            SHIFT:   if (shift_last) state_next = HOLD;
            HOLD:    if (!Execute) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            a        <= '0;
            b        <= '0;
            f_q      <= '0;
            r_q      <= '0;
            op_count <= '0;
            fresh    <= 1'b0;
        end else begin
            fresh <= 1'b0;
            case (state)
                IDLE: begin
                    if (LoadA) a <= Din;
                    if (LoadB) b <= Din;
                    if (Execute && !LoadA && !LoadB) begin
                        f_q <= F;
                        r_q <= R;
                    end
                end
                SHIFT: begin
                    a <= a_new;
                    b <= b_new;
                    if (shift_last) begin
                        op_count <= op_count + 1'b1;
                        fresh    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Aval      = a;
        Bval      = b;
        OpCount   = op_count;
        Busy      = (state == SHIFT);
        Done      = (state == HOLD) && fresh;
        fsm_state = state;
    end

endmodule

// File: doc/serial_logic_processor.md
Name: serial_logic_processor

Overview:
- Parametrised successor to the 4-bit logic processor: two WIDTH-bit registers A and B, loadable from Din.
- On Execute, applies a bitwise function F to A and B serially, one bit per clock, LSB first.
- Routes the result back into A and/or B according to R.
- Adds latched operands, busy/done status and an operation counter. Sits between the switch/button debouncers and the hex-display drivers in the lab top level.

Parameters:
WIDTH, 8, register width in bits (>=2); also the number of serial cycles per operation
CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden)
OPS_W, 8, width of the operation counter OpCount

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-low reset
LoadA  input  1  active-high; A <= Din (IDLE only)
LoadB  input  1  active-high; B <= Din (IDLE only)
Execute  input  1  active-high level request; one operation per assertion
Din  input  WIDTH  load data
F  input  3  function select, sampled at start
R  input  2  routing select, sampled at start
Aval  output  WIDTH  register A contents
Bval  output  WIDTH  register B contents
Busy  output  1  high while shifting
Done  output  1  one-cycle pulse when an operation completes
OpCount  output  OPS_W  completed operations, wraps modulo 2^OPS_W

Behaviour:
- Reset: Clk edge with Reset=0 sets A=0, B=0, OpCount=0, Busy=0, Done=0 and state IDLE. Applies mid-operation too; the partial result is discarded.
- Functions F: 000 AND, 001 OR, 010 XOR, 011 all-ones, 100 NAND, 101 NOR, 110 XNOR, 111 all-zeros.
- Routing R: 00 A,B unchanged; 01 B<=f(A,B); 10 A<=f(A,B); 11 A<=B and B<=A (swap, F ignored).
- FSM IDLE:
  - LoadA/LoadB are honoured; both asserted together load Din into both registers.
  - Execute=1 at an edge latches F and R into shadow registers, clears the bit counter and moves to SHIFT.
  - If Execute and a load are seen at the same edge, the load is performed and Execute waits for the next edge.
- FSM SHIFT (Busy=1):
  - Each edge computes f from A[0] and B[0].
  - Both registers shift right by 1.
  - MSBs receive: R=00 A[0]->A, B[0]->B; R=01 A[0]->A, f->B; R=10 f->A, B[0]->B; R=11 B[0]->A, A[0]->B.
  - The counter increments each edge; after exactly WIDTH SHIFT edges the FSM moves to HOLD.
  - Loads and changes on F/R are ignored throughout SHIFT.
- FSM HOLD:
  - Done=1 and OpCount increments in the first HOLD cycle only.
  - Stays in HOLD while Execute=1; returns to IDLE at the first edge with Execute=0.
  - Holding Execute high therefore yields exactly one operation.
- Latency: from the Execute-sampling edge, Aval/Bval are final WIDTH edges later. Busy is high for exactly WIDTH cycles, and Done follows immediately after.
- Aval/Bval show intermediate rotated values during SHIFT. Downstream displays must qualify with Busy.
- OpCount wraps from 2^OPS_W-1 to 0 without any flag.

Optional Feature:
- Macro: SERIAL_LOGIC_PROCESSOR_PARALLEL_EXEC_EN.
- Defined: SHIFT lasts exactly one cycle. The full WIDTH-bit result is computed and routed in a single edge, so Busy is high for 1 cycle, then HOLD/Done as normal. All other rules are unchanged.
- Undefined: serial WIDTH-cycle operation as above. Final register values are identical in both builds.

Test Plan:
1. WIDTH=8; Reset=0 for one edge -> Aval=0x00, Bval=0x00, Busy=0, Done=0, OpCount=0.
2. Load A=0xB5, B=0x2C; F=010, R=10; pulse Execute -> Busy high exactly 8 cycles, one Done pulse, Aval=0x99, Bval=0x2C, OpCount=1.
3. Continue: F=110, R=01; Execute -> Aval=0x99, Bval=0x4A, OpCount=2. Then R=11 -> Aval=0x4A, Bval=0x99, OpCount=3.
4. Hold Execute high for 40 cycles -> exactly one operation, one Done pulse, OpCount increments by 1. Assert LoadA with Din=0xFF and change F while Busy -> ignored, result per the latched F/R.
5. Start an operation, assert Reset=0 at shift cycle 4 -> next edge Aval=Bval=0, IDLE, Busy=0, no Done, OpCount=0.
6. Build with SERIAL_LOGIC_PROCESSOR_PARALLEL_EXEC_EN; repeat scenario 2 -> Busy high 1 cycle, same Aval=0x99, Bval=0x2C.
